bus_fifo_port: RTL and testbench
================================

// Module: bus_fifo_port
// PURPOSE
// - Memory-mapped responder on the processor data bus (ADDR/DOUT/W -> read data): a write-side mailbox FIFO.
// - Processor pushes words with st and reads head/status with ld; a downstream consumer drains via valid/ready.
// - Sits beside wram/port_n behind the chip-select decode; its RDATA feeds the processor DIN read mux.
// PARAMETERS
// - WIDTH  16    data word width
// - AW     3     pointer width; DEPTH = 2**AW = 8 entries
// - BASE   4'h3  ADDR[15:12] value that selects this block
// PORTS
// - Clock     in   1      system clock, all state on posedge
// - Resetn    in   1      synchronous, active-low reset
// - ADDR      in   16     processor address register output
// - WDATA     in   WIDTH  processor DOUT register output
// - W         in   1      processor write strobe, high exactly one cycle per st
// - RDATA     out  WIDTH  registered read data toward DIN mux
// - rd_sel    out  1      registered: RDATA valid for this block (DIN mux select)
// - out_data  out  WIDTH  head entry toward consumer
// - out_valid out  1      FIFO not empty
// - out_ready in   1      consumer accepts head this cycle
// - count     out  AW+1   occupancy 0..DEPTH
// BEHAVIOUR
// - sel = (ADDR[15:12]==BASE); offset = ADDR[1:0]; ADDR[11:2] ignored.
// - Writes (sel & W): off0 PUSH WDATA; off1 no effect; off2 POP (discard head); off3 CLEAR (flush + clear flags).
// - Reads are side-effect free (no read strobe exists; ADDR is held several cycles).
// - Read latency 1: RDATA/rd_sel registered every cycle from current ADDR, matching wram timing (ADDR in T3, sampled T5).
//   off0 -> head (0 if empty); off1 -> status; off2/off3 -> 0; not sel -> RDATA=0, rd_sel=0.
// - Status: [15] overflow, [14] underflow, [13] full, [12] empty, [AW:0] count, others 0.
// - pop_req = (out_valid & out_ready) | (POP write); both in one cycle -> exactly one entry removed.
// - PUSH when full: if pop_req same cycle, push accepted (count unchanged); else word dropped, overflow<=1.
// - POP write when empty: no pointer change, underflow<=1; consumer handshake ignored when empty.
// - Simultaneous push+pop when empty: push stored, pop_req ignored (out_valid was 0), count->1.
// - CLEAR: rd_ptr=wr_ptr=count=0, overflow=underflow=0; overrides a concurrent consumer pop.
// - Pointers wrap modulo DEPTH; count is AW+1 bits, never exceeds DEPTH nor underflows.
// - out_data = mem[rd_ptr] combinational; out_valid = (count!=0); full = (count==DEPTH).
// - Resetn=0 (any time, incl. mid-transfer): ptrs, count, flags, RDATA, rd_sel = 0; out_valid=0; mem contents undefined.
// STRUCTURE
// - Shared include bus_map.vh: region codes (BASE values for RAM, LED, SEG, PORT, FIFO) and offsets OFF_DATA=0, OFF_STAT=1, OFF_POP=2, OFF_CLR=3.
// - One sub-module fifo_mem: WIDTH x DEPTH array, sync write, async read by rd_ptr.
// - Top holds decode, pointers/count, flags and registered read mux.
// TESTING
// - Reset, then read 0x3001 -> next cycle RDATA=0x1000 (empty), rd_sel=1; out_valid=0.
// - Write 0x0011,0x0022 to 0x3000; read 0x3000 -> 0x0011; out_ready=1 one cycle -> out_data=0x0022, count=1.
// - Push 9 words with out_ready=0 -> count=8, status=0xA008 (overflow, full); 9th word absent on drain.
// - Write 0x3002 while empty -> status 0x5000 (underflow, empty); write 0x3003 -> status 0x1000.
// - Full FIFO, push with out_ready=1 same cycle -> count stays 8, no overflow; POP write + out_ready same cycle -> count-1 only.
// - Assert Resetn=0 with count=5 mid-drain -> next cycle count=0, out_valid=0, RDATA=0; read 0x1000 -> rd_sel=0.

Source files
------------

// File: rtl/bus_fifo_port_pkg.sv
// Shared bus-map constants and types for the processor mailbox FIFO port.
// The FIFO region code and the word offsets decoded inside that region.
package bus_fifo_port_pkg;

    localparam logic [3:0] REGION_FIFO = 4'h3;

    typedef enum logic [1:0] {
        OFF_DATA = 2'd0,
        OFF_STAT = 2'd1,
        OFF_POP  = 2'd2,
        OFF_CLR  = 2'd3
    } bus_off_e;

    typedef struct packed {
        logic push;
        logic pop;
        logic clear;
    } bus_cmd_t;

endpackage

// File: rtl/bus_fifo_port_if.sv
// Processor data-bus slot plus downstream valid/ready drain for the mailbox FIFO.
interface bus_fifo_port_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic [15:0]      ADDR;
    logic [WIDTH-1:0] WDATA;
    logic             W;
    logic [WIDTH-1:0] RDATA;
    logic             rd_sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [AW:0]      count;

    modport slave (
        input  ADDR, WDATA, W, out_ready,
        output RDATA, rd_sel, out_data, out_valid, count
    );

    modport master (
        output ADDR, WDATA, W, out_ready,
        input  RDATA, rd_sel, out_data, out_valid, count
    );
endinterface

// File: rtl/bus_fifo_port_fifo_mem.sv
// Storage array for the mailbox FIFO: synchronous write, asynchronous read.
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             Clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; contents are only observable after a push.
    always_ff @(posedge Clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/bus_fifo_port.sv
// Memory-mapped mailbox FIFO: processor pushes/pops/clears via st, reads head and
// status via ld with one-cycle registered latency; a consumer drains via valid/ready.
module bus_fifo_port
    import bus_fifo_port_pkg::*;
#(
    parameter int         WIDTH = 16,
    parameter int         AW    = 3,
    parameter logic [3:0] BASE  = REGION_FIFO
) (
    input  logic          Clock,
    input  logic          Resetn,
    bus_fifo_port_if.slave bus
);
    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] DEPTH_CT = (AW + 1)'(DEPTH);

    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count_q;
    logic             overflow;
    logic             underflow;
    logic [WIDTH-1:0] rdata_q;
    logic             rd_sel_q;

    logic             sel;
    bus_off_e         off;
    bus_cmd_t         cmd;
    logic             empty;
    logic             full;
    logic             pop_req;
    logic             pop_ok;
    logic             push_ok;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] rdata_d;
    logic             unused_addr;

    assign unused_addr = ^bus.ADDR[11:2];

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        sel       = (bus.ADDR[15:12] == BASE);
        off       = bus_off_e'(bus.ADDR[1:0]);
        cmd       = '0;
        cmd.push  = sel && bus.W && (off == OFF_DATA);
        cmd.pop   = sel && bus.W && (off == OFF_POP);
        cmd.clear = sel && bus.W && (off == OFF_CLR);

        empty   = (count_q == '0);
        full    = (count_q == DEPTH_CT);
        pop_req = (!empty && bus.out_ready) || cmd.pop;
        pop_ok  = pop_req && !empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok = cmd.push && (!full || pop_ok);
    end

    always_comb begin
        status            = '0;
        status[WIDTH-1]   = overflow;
        status[WIDTH-2]   = underflow;
        status[WIDTH-3]   = full;
        status[WIDTH-4]   = empty;
        status[AW:0]      = count_q;
    end

    always_comb begin
        rdata_d = '0;
        if (sel) begin
            case (off)
                OFF_DATA: rdata_d = empty ? '0 : head;
                OFF_STAT: rdata_d = status;
                default:  rdata_d = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rdata_q   <= '0;
            rd_sel_q  <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rd_sel_q <= sel;

            if (cmd.clear) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count_q   <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
                if (cmd.push && !push_ok) begin
                    overflow <= 1'b1;
                end
                if (cmd.pop && empty) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .Clock (Clock),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (bus.WDATA),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign bus.out_data  = head;
    assign bus.out_valid = !empty;
    assign bus.count     = count_q;
    assign bus.RDATA     = rdata_q;
    assign bus.rd_sel    = rd_sel_q;
endmodule

// File: tb/tb_bus_fifo_port.sv
// Scoreboard bench for bus_fifo_port: a queue model tracks FIFO contents and flags,
// and every cycle checks occupancy, head on drain, and the registered read data.
module tb_bus_fifo_port;

    logic Clock = 1'b0;
    logic Resetn;
    int   tests_run  = 0;
    int   tests_fail = 0;

    logic [15:0] sb [$];
    logic        m_ov;
    logic        m_un;

    bus_fifo_port_if #(.WIDTH(16), .AW(3)) bus ();

    bus_fifo_port #(.WIDTH(16), .AW(3), .BASE(4'h3)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // One bus cycle: drive, check pre-edge outputs against the model, clock, check RDATA.
    task automatic cycle(input logic [15:0] addr, input logic [15:0] data,
                         input logic w, input logic ready);
        logic        sel, push, popw, clr, empty, full, cons, pop, exp_sel;
        logic [1:0]  off;
        logic [15:0] exp_rd, stat, head;

        bus.ADDR      = addr;
        bus.WDATA     = data;
        bus.W         = w;
        bus.out_ready = ready;
        #1;

        sel   = (addr[15:12] == 4'h3);
        off   = addr[1:0];
        push  = sel && w && (off == 2'd0);
        popw  = sel && w && (off == 2'd2);
        clr   = sel && w && (off == 2'd3);
        empty = (sb.size() == 0);
        full  = (sb.size() == 8);
        head  = empty ? 16'h0 : sb[0];
        stat  = {m_ov, m_un, full, empty, 8'h00, 4'(sb.size())};

        tests_run++;
        if (bus.count !== 4'(sb.size())) begin
            tests_fail++;
            $display("FAIL count: got %0d expected %0d", bus.count, sb.size());
        end
        tests_run++;
        if (bus.out_valid !== !empty) begin
            tests_fail++;
            $display("FAIL out_valid: got %b expected %b", bus.out_valid, !empty);
        end

        cons = ready && !empty;
        if (cons) begin
            tests_run++;
            if (bus.out_data !== sb[0]) begin
                tests_fail++;
                $display("FAIL out_data: got %h expected %h", bus.out_data, sb[0]);
            end
        end

        exp_sel = sel;
        if (!sel)              exp_rd = 16'h0;
        else if (off == 2'd0)  exp_rd = head;
        else if (off == 2'd1)  exp_rd = stat;
        else                   exp_rd = 16'h0;

        step();

        tests_run++;
        if (bus.RDATA !== exp_rd || bus.rd_sel !== exp_sel) begin
            tests_fail++;
            $display("FAIL rdata @%h: got %h/%b expected %h/%b",
                     addr, bus.RDATA, bus.rd_sel, exp_rd, exp_sel);
        end

        if (clr) begin
            sb.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            pop = (cons || popw) && !empty;
            if (popw && empty) m_un = 1'b1;
            if (pop) void'(sb.pop_front());
            if (push) begin
                if (!full || pop) sb.push_back(data);
                else              m_ov = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        step();
        step();
        sb.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        bus.ADDR = 16'h0000; bus.WDATA = 16'h0; bus.W = 1'b0; bus.out_ready = 1'b0;
        do_reset();
        tests_run++;
        if (bus.count !== 4'd0 || bus.out_valid !== 1'b0 || bus.RDATA !== 16'h0 || bus.rd_sel !== 1'b0) begin
            tests_fail++;
            $display("FAIL reset_state: count=%0d valid=%b rdata=%h rd_sel=%b expected 0/0/0000/0",
                     bus.count, bus.out_valid, bus.RDATA, bus.rd_sel);
        end
        cycle(16'h3001, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if (bus.RDATA !== 16'h1000 || bus.rd_sel !== 1'b1) begin
            tests_fail++;
            $display("FAIL reset_status: got %h/%b expected 1000/1", bus.RDATA, bus.rd_sel);
        end
    endtask

    task automatic test_push_read();
        cycle(16'h3000, 16'h0011, 1'b1, 1'b0);
        cycle(16'h3000, 16'h0022, 1'b1, 1'b0);
        cycle(16'h3000, 16'h0000, 1'b0, 1'b0);
        tests_run++;
        if (bus.RDATA !== 16'h0011) begin
            tests_fail++;
            $display("FAIL head_read: got %h expected 0011", bus.RDATA);
        end
        cycle(16'h3000, 16'h0000, 1'b0, 1'b1);
        bus.out_ready = 1'b0;
        #1;
        tests_run++;
        if (bus.out_data !== 16'h0022 || bus.count !== 4'd1) begin
            tests_fail++;
            $display("FAIL consumer_pop: got %h/%0d expected 0022/1", bus.out_data, bus.count);
        end
        cycle(16'h3001, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) cycle(16'h3000, 16'h0100 + 16'(i), 1'b1, 1'b0);
        cycle(16'h3FF1, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if (bus.RDATA !== 16'hA008 || bus.count !== 4'd8) begin
            tests_fail++;
            $display("FAIL overflow_status: got %h/%0d expected A008/8", bus.RDATA, bus.count);
        end
        for (int i = 0; i < 9; i++) cycle(16'h3001, 16'h0, 1'b0, 1'b1);
        tests_run++;
        if (bus.RDATA !== 16'h9000) begin
            tests_fail++;
            $display("FAIL overflow_sticky: got %h expected 9000", bus.RDATA);
        end
        cycle(16'h3003, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_underflow_clear();
        cycle(16'h3002, 16'h0, 1'b1, 1'b0);
        cycle(16'h3001, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if (bus.RDATA !== 16'h5000) begin
            tests_fail++;
            $display("FAIL underflow_status: got %h expected 5000", bus.RDATA);
        end
        cycle(16'h3003, 16'h0, 1'b1, 1'b0);
        cycle(16'h3001, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if (bus.RDATA !== 16'h1000) begin
            tests_fail++;
            $display("FAIL clear_status: got %h expected 1000", bus.RDATA);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) cycle(16'h3000, 16'h0A00 + 16'(i), 1'b1, 1'b0);
        cycle(16'h3000, 16'h0BEE, 1'b1, 1'b1);
        cycle(16'h3001, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if (bus.RDATA !== 16'h2008) begin
            tests_fail++;
            $display("FAIL full_push_pop: got %h expected 2008", bus.RDATA);
        end
        cycle(16'h3002, 16'h0, 1'b1, 1'b1);
        tests_run++;
        if (bus.count !== 4'd7) begin
            tests_fail++;
            $display("FAIL dual_pop: got %0d expected 7", bus.count);
        end
        cycle(16'h3003, 16'h0, 1'b1, 1'b1);
        tests_run++;
        if (bus.count !== 4'd0) begin
            tests_fail++;
            $display("FAIL clear_over_pop: got %0d expected 0", bus.count);
        end
        // Push into empty while the consumer is ready: entry must stay.
        cycle(16'h3000, 16'h0C0C, 1'b1, 1'b1);
        tests_run++;
        if (bus.count !== 4'd1) begin
            tests_fail++;
            $display("FAIL push_empty_ready: got %0d expected 1", bus.count);
        end
        cycle(16'h3001, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) cycle(16'h3000, 16'h0D00 + 16'(i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(16'h3001, 16'h0, 1'b0, 1'b1);
        tests_run++;
        if (bus.count !== 4'd5) begin
            tests_fail++;
            $display("FAIL mid_count: got %0d expected 5", bus.count);
        end
        bus.ADDR = 16'h3001;
        Resetn   = 1'b0;
        step();
        sb.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        tests_run++;
        if (bus.count !== 4'd0 || bus.out_valid !== 1'b0 || bus.RDATA !== 16'h0 || bus.rd_sel !== 1'b0) begin
            tests_fail++;
            $display("FAIL mid_reset: count=%0d valid=%b rdata=%h rd_sel=%b expected 0/0/0000/0",
                     bus.count, bus.out_valid, bus.RDATA, bus.rd_sel);
        end
        Resetn = 1'b1;
        cycle(16'h1000, 16'h0, 1'b0, 1'b1);
        tests_run++;
        if (bus.rd_sel !== 1'b0 || bus.RDATA !== 16'h0) begin
            tests_fail++;
            $display("FAIL other_region: got %h/%b expected 0000/0", bus.RDATA, bus.rd_sel);
        end
    endtask

    initial begin
        m_ov = 1'b0;
        m_un = 1'b0;
        test_reset();
        test_push_read();
        test_overflow();
        test_underflow_clear();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
